// File: rtl/sprite_pkg.sv
// Shared constants and texel-address helper for the sprite compositor.
package sprite_pkg;

  typedef logic [1:0] orient_t;

  localparam orient_t ORI_TRANSPOSE       = 2'd0;
  localparam orient_t ORI_TRANSPOSE_VFLIP = 2'd1;
  localparam orient_t ORI_NORMAL          = 2'd2;
  localparam orient_t ORI_HFLIP           = 2'd3;

  localparam logic [11:0] DEF_KEY_COLOR  = 12'h000;
  localparam logic [11:0] DEF_WALL_COLOR = 12'hfff;
  localparam logic [11:0] DEF_BG_COLOR   = 12'h000;

  // Sprite edges up to 2**8 are supported; callers truncate to 2*SPR_LOG bits.
  function automatic logic [15:0] spr_rom_addr(input logic [7:0] dx,
                                               input logic [7:0] dy,
                                               input orient_t    orient,
                                               input int unsigned lg);
    logic [15:0] m16;
    logic [7:0]  mask;
    logic [7:0]  hi;
    logic [7:0]  lo;
    m16  = (16'd1 << lg) - 16'd1;
    mask = m16[7:0];
    hi   = dy;
    lo   = dx;
    case (orient)
      ORI_TRANSPOSE:       begin hi = dx; lo = dy;        end
      ORI_TRANSPOSE_VFLIP: begin hi = dx; lo = mask - dy; end
      ORI_NORMAL:          begin hi = dy; lo = dx;        end
      default:             begin hi = dy; lo = mask - dx; end
    endcase
    return ({8'd0, hi} << lg) | {8'd0, lo};
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream between the timing generator/map lookup and vgac.
interface sprite_compositor_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 9,
  parameter int RGB_W = 12
);
  logic             pix_valid;
  logic             frame_start;
  logic [COL_W-1:0] col_addr;
  logic [ROW_W-1:0] row_addr;
  logic             is_wall;
  logic             pix_out_valid;
  logic [RGB_W-1:0] vga_data;

  modport master (
    output pix_valid, frame_start, col_addr, row_addr, is_wall,
    input  pix_out_valid, vga_data
  );

  modport slave (
    input  pix_valid, frame_start, col_addr, row_addr, is_wall,
    output pix_out_valid, vga_data
  );
endinterface

// File: rtl/sprite_hit_unit.sv
// One sprite: frame-latched position/orientation, hit test and registered ROM address.
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int SPR_LOG = 5,
  parameter int COL_W   = 10,
  parameter int ROW_W   = 9
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [COL_W-1:0]     col,
  input  logic [ROW_W-1:0]     row,
  input  logic [COL_W-1:0]     spr_x,
  input  logic [ROW_W-1:0]     spr_y,
  input  orient_t              spr_orient,
  input  logic                 spr_en,
  output logic                 hit_p1,
  output logic [2*SPR_LOG-1:0] rom_addr
);

  localparam int SPR_SIZE = 1 << SPR_LOG;

  logic [COL_W-1:0] x_sh, x_eff;
  logic [ROW_W-1:0] y_sh, y_eff;
  orient_t          ori_sh, ori_eff;
  logic             en_sh, en_eff;
  logic [COL_W:0]   col_ext, x_lo, x_hi;
  logic [ROW_W:0]   row_ext, y_lo, y_hi;
  logic [SPR_LOG-1:0] dx, dy;
  logic             hit_c;

  // A pixel arriving with frame_start already sees the newly latched values.
  always_comb begin
    x_eff   = frame_start ? spr_x      : x_sh;
    y_eff   = frame_start ? spr_y      : y_sh;
    ori_eff = frame_start ? spr_orient : ori_sh;
    en_eff  = frame_start ? spr_en     : en_sh;
    col_ext = {1'b0, col};
    row_ext = {1'b0, row};
    x_lo    = {1'b0, x_eff};
    y_lo    = {1'b0, y_eff};
    x_hi    = x_lo + (COL_W+1)'(SPR_SIZE);
    y_hi    = y_lo + (ROW_W+1)'(SPR_SIZE);
    hit_c   = en_eff && (col_ext >= x_lo) && (col_ext < x_hi)
                     && (row_ext >= y_lo) && (row_ext < y_hi);
    dx      = SPR_LOG'(col - x_eff);
    dy      = SPR_LOG'(row - y_eff);
  end

  // Stage A boundary
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      x_sh     <= '0;
      y_sh     <= '0;
      ori_sh   <= '0;
      en_sh    <= 1'b0;
      hit_p1   <= 1'b0;
      rom_addr <= '0;
    end else begin
      if (frame_start) begin
        x_sh   <= spr_x;
        y_sh   <= spr_y;
        ori_sh <= spr_orient;
        en_sh  <= spr_en;
      end
      hit_p1 <= pix_valid & hit_c;
      if (pix_valid)
        rom_addr <= (2*SPR_LOG)'(spr_rom_addr(8'(dx), 8'(dy), ori_eff, SPR_LOG));
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// NUM_SPR-sprite compositor over the wall map, latency 2+ROM_LAT.
// Optional per-frame collision flags when SPRITE_COLLISION_EN is defined.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 4,
  parameter int SPR_LOG = 5,
  parameter int COL_W   = 10,
  parameter int ROW_W   = 9,
  parameter int RGB_W   = 12,
  parameter int ROM_LAT = 1,
  parameter logic [RGB_W-1:0] KEY_COLOR  = RGB_W'(DEF_KEY_COLOR),
  parameter logic [RGB_W-1:0] WALL_COLOR = RGB_W'(DEF_WALL_COLOR),
  parameter logic [RGB_W-1:0] BG_COLOR   = RGB_W'(DEF_BG_COLOR)
) (
  input  logic                           clk,
  input  logic                           clrn,
  sprite_compositor_if.slave             pif,
  input  logic [NUM_SPR*COL_W-1:0]       spr_x,
  input  logic [NUM_SPR*ROW_W-1:0]       spr_y,
  input  logic [NUM_SPR*2-1:0]           spr_orient,
  input  logic [NUM_SPR-1:0]             spr_en,
  output logic [NUM_SPR*2*SPR_LOG-1:0]   rom_addr,
  input  logic [NUM_SPR*RGB_W-1:0]       rom_data
`ifdef SPRITE_COLLISION_EN
  ,output logic [NUM_SPR-1:0]            collide
`endif
);

  logic [NUM_SPR-1:0] hit_p1, hit_p2, opq;
  logic               vld_p1, vld_p2;
  logic               wall_p1, wall_p2;
  logic [RGB_W-1:0]   pix_nxt;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    sprite_hit_unit #(
      .SPR_LOG(SPR_LOG),
      .COL_W  (COL_W),
      .ROW_W  (ROW_W)
    ) u_hit (
      .clk        (clk),
      .clrn       (clrn),
      .frame_start(pif.frame_start),
      .pix_valid  (pif.pix_valid),
      .col        (pif.col_addr),
      .row        (pif.row_addr),
      .spr_x      (spr_x[i*COL_W +: COL_W]),
      .spr_y      (spr_y[i*ROW_W +: ROW_W]),
      .spr_orient (spr_orient[i*2 +: 2]),
      .spr_en     (spr_en[i]),
      .hit_p1     (hit_p1[i]),
      .rom_addr   (rom_addr[i*2*SPR_LOG +: 2*SPR_LOG])
    );
  end

  // Stage A boundary
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vld_p1  <= 1'b0;
      wall_p1 <= 1'b0;
    end else begin
      vld_p1  <= pif.pix_valid;
      wall_p1 <= pif.pix_valid & pif.is_wall;
    end
  end

  // ROM-alignment boundary: ROM_LAT register stages
  if (ROM_LAT == 0) begin : g_nodly
    assign hit_p2  = hit_p1;
    assign vld_p2  = vld_p1;
    assign wall_p2 = wall_p1;
  end else begin : g_dly
    logic [ROM_LAT-1:0][NUM_SPR-1:0] hit_sr;
    logic [ROM_LAT-1:0]              vld_sr, wall_sr;

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        hit_sr  <= '0;
        vld_sr  <= '0;
        wall_sr <= '0;
      end else begin
        hit_sr[0]  <= hit_p1;
        vld_sr[0]  <= vld_p1;
        wall_sr[0] <= wall_p1;
        for (int k = 1; k < ROM_LAT; k++) begin
          hit_sr[k]  <= hit_sr[k-1];
          vld_sr[k]  <= vld_sr[k-1];
          wall_sr[k] <= wall_sr[k-1];
        end
      end
    end

    assign hit_p2  = hit_sr[ROM_LAT-1];
    assign vld_p2  = vld_sr[ROM_LAT-1];
    assign wall_p2 = wall_sr[ROM_LAT-1];
  end

  // Walking from the highest index down lets the lowest opaque index win.
  always_comb begin
    opq     = '0;
    pix_nxt = BG_COLOR;
    for (int i = 0; i < NUM_SPR; i++)
      opq[i] = hit_p2[i] && (rom_data[i*RGB_W +: RGB_W] != KEY_COLOR);
    for (int i = NUM_SPR-1; i >= 0; i--)
      if (opq[i]) pix_nxt = rom_data[i*RGB_W +: RGB_W];
    if (wall_p2) pix_nxt = WALL_COLOR;
    if (!vld_p2) pix_nxt = BG_COLOR;
  end

  // Stage B boundary
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pif.vga_data      <= '0;
      pif.pix_out_valid <= 1'b0;
    end else begin
      pif.vga_data      <= pix_nxt;
      pif.pix_out_valid <= vld_p2;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPR-1:0] coll_acc, coll_cur;

  always_comb begin
    coll_cur    = '0;
    coll_cur[0] = vld_p2 & wall_p2 & opq[0];
    for (int i = 1; i < NUM_SPR; i++)
      coll_cur[i] = vld_p2 & opq[0] & opq[i];
  end

  // The pixel resolved in the frame_start cycle opens the new frame's tally.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      coll_acc <= '0;
      collide  <= '0;
    end else if (pif.frame_start) begin
      collide  <= coll_acc;
      coll_acc <= coll_cur;
    end else begin
      coll_acc <= coll_acc | coll_cur;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a one-cycle-latency sprite ROM model.
module tb_sprite_compositor;

  localparam int NS = 4;
  localparam int SL = 5;
  localparam int CW = 10;
  localparam int RW = 9;
  localparam int GW = 12;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  sprite_compositor_if #(.COL_W(CW), .ROW_W(RW), .RGB_W(GW)) pif();

  logic [NS*CW-1:0]   spr_x;
  logic [NS*RW-1:0]   spr_y;
  logic [NS*2-1:0]    spr_orient;
  logic [NS-1:0]      spr_en;
  logic [NS*2*SL-1:0] rom_addr;
  logic [NS*GW-1:0]   rom_data;
`ifdef SPRITE_COLLISION_EN
  logic [NS-1:0]      collide;
`endif

  logic [GW-1:0] mem [NS][1024];
  logic [GW-1:0] rd  [NS];

  sprite_compositor dut (
    .clk       (clk),
    .clrn      (clrn),
    .pif       (pif),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .spr_orient(spr_orient),
    .spr_en    (spr_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
`ifdef SPRITE_COLLISION_EN
    ,.collide  (collide)
`endif
  );

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++)
      rd[i] <= mem[i][rom_addr[i*2*SL +: 2*SL]];
  end
  assign rom_data = {rd[3], rd[2], rd[1], rd[0]};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_spr(input int i, input logic [CW-1:0] x, input logic [RW-1:0] y,
                         input logic [1:0] o, input logic en);
    spr_x[i*CW +: CW]   = x;
    spr_y[i*RW +: RW]   = y;
    spr_orient[i*2 +: 2] = o;
    spr_en[i]           = en;
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    pif.frame_start = 1'b1;
    @(negedge clk);
    pif.frame_start = 1'b0;
  endtask

  // Present one pixel for a single cycle; returns just after the sampling edge.
  task automatic pixel(input logic [CW-1:0] c, input logic [RW-1:0] r,
                       input logic w, input logic v, input logic fs);
    @(negedge clk);
    pif.col_addr    = c;
    pif.row_addr    = r;
    pif.is_wall     = w;
    pif.pix_valid   = v;
    pif.frame_start = fs;
    @(negedge clk);
    pif.pix_valid   = 1'b0;
    pif.frame_start = 1'b0;
    pif.is_wall     = 1'b0;
  endtask

  task automatic out(input string tag, input logic [GW-1:0] exp_rgb, input logic exp_vld);
    @(negedge clk);
    chk({tag, "_early"}, {31'd0, pif.pix_out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, pif.pix_out_valid}, {31'd0, exp_vld});
    chk({tag, "_rgb"}, {20'd0, pif.vga_data}, {20'd0, exp_rgb});
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return 32'(rom_addr[i*2*SL +: 2*SL]);
  endfunction

  initial begin
    for (int i = 0; i < NS; i++)
      for (int a = 0; a < 1024; a++)
        mem[i][a] = 12'h000;
    mem[0][69]  = 12'h123;
    mem[0][90]  = 12'h456;
    mem[0][189] = 12'h789;
    mem[0][340] = 12'hf00;
    mem[1][170] = 12'h0f0;
    mem[2][108] = 12'h00f;
    mem[2][117] = 12'h00f;

    clrn = 1'b0;
    pif.pix_valid = 1'b0; pif.frame_start = 1'b0; pif.is_wall = 1'b0;
    pif.col_addr = '0; pif.row_addr = '0;
    spr_x = '0; spr_y = '0; spr_orient = '0; spr_en = '0;
    set_spr(0, 10'd100, 9'd50, 2'b10, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_vga", {20'd0, pif.vga_data}, 32'd0);
    chk("rst_vld", {31'd0, pif.pix_out_valid}, 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    clrn = 1'b1;

    // No frame_start yet: shadow is all zero, sprite 0 disabled, orient 00.
    pixel(10'd105, 9'd52, 1'b0, 1'b1, 1'b0);
    chk("nofs_addr", addr_of(0), 32'd308);
    out("nofs", 12'h000, 1'b1);
    pixel(10'd100, 9'd100, 1'b0, 1'b1, 1'b0);
    out("bg100", 12'h000, 1'b1);

    pulse_fs();
    pixel(10'd105, 9'd52, 1'b0, 1'b1, 1'b0);
    chk("o10_addr", addr_of(0), 32'd69);
    out("o10", 12'h123, 1'b1);

    // Orientation change without frame_start stays invisible.
    spr_orient[1:0] = 2'b11;
    pixel(10'd105, 9'd52, 1'b0, 1'b1, 1'b0);
    chk("o11mid_addr", addr_of(0), 32'd69);
    out("o11mid", 12'h123, 1'b1);
    pulse_fs();
    pixel(10'd105, 9'd52, 1'b0, 1'b1, 1'b0);
    chk("o11_addr", addr_of(0), 32'd90);
    out("o11", 12'h456, 1'b1);

    // frame_start coincident with the pixel uses the new orientation.
    spr_orient[1:0] = 2'b01;
    pixel(10'd105, 9'd52, 1'b0, 1'b1, 1'b1);
    chk("o01_addr", addr_of(0), 32'd189);
    out("o01", 12'h789, 1'b1);

    set_spr(0, 10'd100, 9'd50, 2'b10, 1'b1);
    set_spr(1, 10'd110, 9'd55, 2'b10, 1'b1);
    pulse_fs();
    pixel(10'd120, 9'd60, 1'b0, 1'b1, 1'b0);
    chk("ovl_addr0", addr_of(0), 32'd340);
    chk("ovl_addr1", addr_of(1), 32'd170);
    out("ovl_s0", 12'hf00, 1'b1);
    mem[0][340] = 12'h000;
    pixel(10'd120, 9'd60, 1'b0, 1'b1, 1'b0);
    out("ovl_s1", 12'h0f0, 1'b1);
    pixel(10'd120, 9'd60, 1'b1, 1'b1, 1'b0);
    out("ovl_wall", 12'hfff, 1'b1);
    pixel(10'd120, 9'd60, 1'b1, 1'b0, 1'b0);
    out("novld", 12'h000, 1'b0);

    // Right-edge sprite must not wrap onto low columns.
    set_spr(2, 10'd1008, 9'd0, 2'b10, 1'b1);
    pulse_fs();
    pixel(10'd1020, 9'd3, 1'b0, 1'b1, 1'b0);
    chk("edge_addr", addr_of(2), 32'd108);
    out("edge_in", 12'h00f, 1'b1);
    pixel(10'd5, 9'd3, 1'b0, 1'b1, 1'b0);
    chk("wrap_addr", addr_of(2), 32'd117);
    out("wrap_out", 12'h000, 1'b1);

    // Mid-frame x move takes effect only at the next frame_start.
    spr_x[9:0] = 10'd200;
    pixel(10'd105, 9'd52, 1'b0, 1'b1, 1'b0);
    out("xmid", 12'h123, 1'b1);
    pulse_fs();
    pixel(10'd105, 9'd52, 1'b0, 1'b1, 1'b0);
    chk("xnew_addr", addr_of(0), 32'd65);
    out("xnew", 12'h000, 1'b1);

`ifdef SPRITE_COLLISION_EN
    set_spr(2, 10'd200, 9'd50, 2'b10, 1'b1);
    mem[2][69] = 12'h00f;
    pulse_fs();
    pixel(10'd205, 9'd52, 1'b0, 1'b1, 1'b0);
    out("coll_pix", 12'h123, 1'b1);
    pulse_fs();
    chk("coll_n", 32'(collide), 32'h4);
    pulse_fs();
    chk("coll_n1", 32'(collide), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
